// File: rtl/peripheral_logic_node_pkg.sv
// Shared types for the peripheral clock/power node array: node state encoding
// and the decode helpers used by each channel.
package peripheral_logic_node_pkg;

  typedef enum logic [2:0] {
    READY    = 3'b000,
    SILENT   = 3'b001,
    STOPPING = 3'b010,
    FILTER   = 3'b100,
    STARTING = 3'b101
  } node_state_t;

  // READY and FILTER both still present the clock as usable downstream.
  function automatic logic is_ready(node_state_t s);
    return (s == READY) || (s == FILTER);
  endfunction

  function automatic logic is_stopping(node_state_t s);
    return (s == FILTER) || (s == STOPPING);
  endfunction

endpackage

// File: rtl/peripheral_logic_node_channel.sv
// One peripheral node: request-drop deglitch filter plus stop/start handshake FSM.
// Optional handshake timeout monitor enabled by PERIPH_NODE_TIMEOUT_EN.
module peripheral_logic_node_channel
  import peripheral_logic_node_pkg::*;
#(
  parameter int FILTER_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic async_resetn,
  input  logic request,
  input  logic started,
  input  logic stopped,
  input  logic timeout_clr,
  output logic peripheral_stopping,
  output logic internal_request,
  output logic internal_silent,
  output logic internal_ready,
  output logic internal_stopping,
  output logic internal_starting,
  output logic timeout_err
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

  node_state_t   state;
  logic [FW-1:0] filt_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state    <= SILENT;
      filt_cnt <= '0;
    end else begin
      case (state)
        SILENT:   if (request) state <= STARTING;
        STARTING: if (started) state <= READY;
        READY: begin
          if (!request) begin
            state    <= FILTER;
            filt_cnt <= '0;
          end
        end
        FILTER: begin
          if (request) begin
            state    <= READY;
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_LAST) begin
            state <= STOPPING;
          end else begin
            filt_cnt <= filt_cnt + FW'(1);
          end
        end
        STOPPING: if (stopped) state <= SILENT;
        // Illegal encodings (e.g. after an upset) recover to the idle state.
        default:  state <= SILENT;
      endcase
    end
  end

  assign peripheral_stopping = (state == STOPPING);
  assign internal_request    = (state != SILENT);
  assign internal_silent     = (state == SILENT) && !request;
  assign internal_ready      = is_ready(state);
  assign internal_stopping   = is_stopping(state);
  assign internal_starting   = (state == STARTING);

`ifdef PERIPH_NODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          waiting;
  logic          to_set;

  assign waiting = (state == STARTING) || (state == STOPPING);
  // Set fires on the edge the count reaches TIMEOUT_CYCLES and keeps firing
  // while saturated, so a coinciding clear cannot drop the flag.
  assign to_set  = waiting && (to_cnt >= TO_LAST);

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!waiting)              to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);

      if (to_set)           timeout_err <= 1'b1;
      else if (timeout_clr) timeout_err <= 1'b0;
    end
  end
`else
  assign timeout_err = 1'b0;
  wire unused_timeout = &{1'b0, timeout_clr, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: rtl/peripheral_logic_node_array.sv
// NUM_CH independent peripheral clock/power nodes with aggregate flags for the
// domain power controller. Timeout monitor enabled by PERIPH_NODE_TIMEOUT_EN.
module peripheral_logic_node_array #(
  parameter int NUM_CH         = 4,
  parameter int FILTER_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              async_resetn,
  input  logic [NUM_CH-1:0] request,
  input  logic [NUM_CH-1:0] stopped,
  input  logic [NUM_CH-1:0] started,
  output logic [NUM_CH-1:0] peripheral_stopping,
  output logic [NUM_CH-1:0] internal_request,
  output logic [NUM_CH-1:0] internal_silent,
  output logic [NUM_CH-1:0] internal_ready,
  output logic [NUM_CH-1:0] internal_stopping,
  output logic [NUM_CH-1:0] internal_starting,
  output logic              all_silent,
  output logic              any_ready,
  output logic [NUM_CH-1:0] timeout_err,
  input  logic [NUM_CH-1:0] timeout_clr
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    peripheral_logic_node_channel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clock              (clock),
      .async_resetn       (async_resetn),
      .request            (request[i]),
      .started            (started[i]),
      .stopped            (stopped[i]),
      .timeout_clr        (timeout_clr[i]),
      .peripheral_stopping(peripheral_stopping[i]),
      .internal_request   (internal_request[i]),
      .internal_silent    (internal_silent[i]),
      .internal_ready     (internal_ready[i]),
      .internal_stopping  (internal_stopping[i]),
      .internal_starting  (internal_starting[i]),
      .timeout_err        (timeout_err[i])
    );
  end

  assign all_silent = &internal_silent;
  assign any_ready  = |internal_ready;

endmodule

// File: tb/tb_peripheral_logic_node_array.sv
// Directed bench for peripheral_logic_node_array (NUM_CH=4, FILTER_CYCLES=3,
// TIMEOUT_CYCLES=8) with a queue scoreboard of expected output snapshots.
module tb_peripheral_logic_node_array;

  localparam int N = 4;

  typedef enum {B_SIL, B_START, B_RDY, B_FILT, B_STOP} bst_t;
  typedef struct {
    string       tag;
    logic [29:0] v;
  } sb_t;

  logic         clock = 1'b0;
  logic         async_resetn;
  logic [N-1:0] request, stopped, started, timeout_clr;
  logic [N-1:0] peripheral_stopping, internal_request, internal_silent;
  logic [N-1:0] internal_ready, internal_stopping, internal_starting, timeout_err;
  logic         all_silent, any_ready;

  bst_t         st[N];
  logic [N-1:0] tmask;
  logic [N-1:0] texp;
  sb_t          sb[$];
  int           total = 0;
  int           bad   = 0;

  peripheral_logic_node_array #(
    .NUM_CH(N), .FILTER_CYCLES(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .async_resetn(async_resetn), .request(request),
    .stopped(stopped), .started(started),
    .peripheral_stopping(peripheral_stopping), .internal_request(internal_request),
    .internal_silent(internal_silent), .internal_ready(internal_ready),
    .internal_stopping(internal_stopping), .internal_starting(internal_starting),
    .all_silent(all_silent), .any_ready(any_ready),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 clock = ~clock;

  // Output decode straight from the per-state output table.
  function automatic logic [29:0] exp_vec();
    logic [N-1:0] ps, ireq, isil, irdy, istop, istart;
    for (int i = 0; i < N; i++) begin
      ps[i]     = (st[i] == B_STOP);
      ireq[i]   = (st[i] != B_SIL);
      isil[i]   = (st[i] == B_SIL) && !request[i];
      irdy[i]   = (st[i] == B_RDY) || (st[i] == B_FILT);
      istop[i]  = (st[i] == B_FILT) || (st[i] == B_STOP);
      istart[i] = (st[i] == B_START);
    end
    return {ps, ireq, isil, irdy, istop, istart, &isil, |irdy, texp & tmask};
  endfunction

  task automatic push_exp(input string tag);
    sb_t e;
    e.tag = tag;
    e.v   = exp_vec();
    sb.push_back(e);
  endtask

  task automatic pop_check();
    sb_t         e;
    logic [29:0] obs;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty obs=none exp=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {peripheral_stopping, internal_request, internal_silent, internal_ready,
           internal_stopping, internal_starting, all_silent, any_ready,
           timeout_err & tmask};
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic check_now(input string tag);
    push_exp(tag);
    #1;
    pop_check();
  endtask

  task automatic tick(input string tag);
    push_exp(tag);
    @(posedge clock);
    #1;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) st[i] = B_SIL;
`ifdef PERIPH_NODE_TIMEOUT_EN
    tmask = 4'b1000;
`else
    tmask = 4'b1111;
`endif
    texp         = '0;
    async_resetn = 1'b0;
    request      = '0;
    stopped      = '0;
    started      = '0;
    timeout_clr  = '0;
    #11;
    check_now("rst_idle");
    request = 4'b0001;
    check_now("rst_req0");
    request = '0;
    #3;
    async_resetn = 1'b1;

    // ch0 start handshake
    request[0] = 1'b1; st[0] = B_START; tick("ch0_starting");
    tick("ch0_wait_started");
    started[0] = 1'b1; st[0] = B_RDY; tick("ch0_ready");
    started[0] = 1'b0;

    // Drop: three FILTER cycles, STOPPING on the fourth edge
    request[0] = 1'b0; st[0] = B_FILT; tick("ch0_filter1");
    tick("ch0_filter2");
    tick("ch0_filter3");
    st[0] = B_STOP; tick("ch0_stopping");

    // Re-request during STOPPING: one SILENT cycle then STARTING
    request[0] = 1'b1; tick("ch0_stop_ignores_req");
    stopped[0] = 1'b1; st[0] = B_SIL; tick("ch0_silent_req_high");
    stopped[0] = 1'b0; st[0] = B_START; tick("ch0_restart");
    started[0] = 1'b1; st[0] = B_RDY; tick("ch0_ready2");
    started[0] = 1'b0;

    // Deglitch: low two cycles then high returns to READY
    request[0] = 1'b0; st[0] = B_FILT; tick("deg_filter1");
    tick("deg_filter2");
    request[0] = 1'b1; st[0] = B_RDY; tick("deg_back_ready");
    tick("deg_hold_ready");

    // Independence: ch1 held in STARTING, ch2 driven to STOPPING
    request[1] = 1'b1; request[2] = 1'b1;
    st[1] = B_START; st[2] = B_START; tick("ind_both_starting");
    started[2] = 1'b1; st[2] = B_RDY; tick("ind_ch2_ready");
    started[2] = 1'b0;
    request[2] = 1'b0; st[2] = B_FILT; tick("ind_ch2_f1");
    tick("ind_ch2_f2");
    tick("ind_ch2_f3");
    st[2] = B_STOP; tick("ind_ch2_stopping");
    started[2] = 1'b1; stopped[1] = 1'b1; stopped[0] = 1'b1; request[1] = 1'b0;
    tick("ind_cross_pulses");
    started[2] = 1'b0; stopped[1] = 1'b0; stopped[0] = 1'b0;
    tick("ind_after_pulses");

    // Timeout on ch3: eight edges in STARTING
    request[3] = 1'b1; st[3] = B_START; tick("to_enter");
    for (int k = 1; k < 7; k++) begin
      @(posedge clock);
    end
    #1;
    tick("to_edge7_clear");
`ifdef PERIPH_NODE_TIMEOUT_EN
    texp[3] = 1'b1;
`endif
    tick("to_edge8_set");
    timeout_clr[3] = 1'b1; tick("to_set_beats_clr");
    timeout_clr[3] = 1'b0; started[3] = 1'b1; st[3] = B_RDY; tick("to_sticky_ready");
    started[3] = 1'b0; timeout_clr[3] = 1'b1; texp[3] = 1'b0; tick("to_cleared");
    timeout_clr[3] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
